ibex_ctx_register_file: RTL
===========================

IBEX_CTX_REGISTER_FILE -- requirements
Module: ibex_ctx_register_file

Interface
REQ-001 SHALL have parameter NumCtx, default 2, number of register contexts (1..16).
REQ-002 SHALL have parameter RV32E, default 1'b0, 1 = 16 registers per context, else 32 (NumRegs).
REQ-003 SHALL have parameter DataWidth, default 32, register word width (32 or 39 with ECC).
REQ-004 SHALL have parameter WordZeroVal, default '0, value of x0, reset and cleared words; CtxW = max(1, clog2(NumCtx)).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async reset, active low.
REQ-006 ctx_sel_i  in  CtxW  active context for reads and core writes.
REQ-007 raddr_a_i / raddr_b_i  in  5  read addresses; rdata_a_o / rdata_b_o  out  DataWidth  read data.
REQ-008 waddr_i  in  5  write address; wdata_i  in  DataWidth  write data; we_i  in  1  write enable.
REQ-009 ra_o  out  DataWidth  x1 of the selected context.
REQ-010 clr_req_i  in  1  clear request; clr_ctx_i  in  CtxW  context to clear.
REQ-011 clr_busy_o  out  1  clear in progress; clr_done_o  out  1  one-cycle completion pulse.

Function
REQ-012 Storage SHALL be NumCtx x NumRegs words; x0 of every context SHALL read WordZeroVal, writes to x0 SHALL be dropped.
REQ-013 Reads SHALL be combinational from context ctx_sel_i; address >= NumRegs (RV32E) SHALL return WordZeroVal.
REQ-014 ctx_sel_i >= NumCtx: reads and ra_o SHALL return WordZeroVal; core writes SHALL be dropped.
REQ-015 Core write SHALL update reg[ctx_sel_i][waddr_i] at the rising edge when we_i=1, waddr_i != 0, waddr_i < NumRegs; visible on reads the next cycle (no write-through bypass).
REQ-016 ra_o SHALL equal reg[ctx_sel_i][1] combinationally.
REQ-017 Clear FSM SHALL have states IDLE and CLEAR plus pointer ptr (5 bits) and captured context cctx.
REQ-018 IDLE: clr_req_i=1 with clr_ctx_i < NumCtx SHALL capture cctx, set ptr=1, go to CLEAR; clr_ctx_i >= NumCtx SHALL be ignored.
REQ-019 CLEAR: each cycle SHALL write WordZeroVal to reg[cctx][ptr] and increment ptr, unless stalled.
REQ-020 Stall: a core write accepted per REQ-015 into context cctx in the same cycle SHALL suppress the engine write; ptr SHALL hold.
REQ-021 After writing ptr = NumRegs-1, FSM SHALL return to IDLE and assert clr_done_o for exactly the next cycle.
REQ-022 clr_busy_o SHALL be 1 exactly while in CLEAR; unstalled clear SHALL take NumRegs-1 busy cycles.
REQ-023 clr_req_i while busy or in the done cycle-state IDLE SHALL follow REQ-018 only in IDLE; requests during CLEAR SHALL be ignored (no queueing).
REQ-024 Core writes to cctx at index >= ptr during CLEAR SHALL end as WordZeroVal; index < ptr SHALL persist.
REQ-025 Reads of cctx during CLEAR SHALL return current storage (partially cleared); contexts other than cctx SHALL be unaffected.

Reset
REQ-026 On rst_ni=0 all words of all contexts SHALL be WordZeroVal, FSM IDLE, ptr=1, cctx=0, clr_busy_o=0, clr_done_o=0, asynchronously.
REQ-027 Reset asserted mid-clear SHALL abort the clear with no done pulse after release.

Verification
REQ-028 Write x5=0xDEADBEEF ctx0, ctx_sel_i=1, read x5 -> 0; ctx_sel_i=0, read x5 -> 0xDEADBEEF.
REQ-029 Write x0=0x1234 -> rdata of x0 = WordZeroVal; write x1=0xA5 -> ra_o = 0xA5 next cycle.
REQ-030 Fill ctx1 x1..x31 nonzero, clr_req_i ctx1 at cycle 0 -> busy cycles 1..31, done pulse cycle 32, all ctx1 reads 0, ctx0 unchanged.
REQ-031 During clear of ctx1, 3 core writes to ctx1 x31 -> busy extends to 34 cycles, x31 reads 0.
REQ-032 RV32E=1: clear takes 15 busy cycles; read address 20 -> WordZeroVal; clr_ctx_i=NumCtx -> no busy.
REQ-033 Assert rst_ni=0 at busy cycle 10 -> busy/done 0 immediately, all words 0, no done after release.

Source files
------------

// File: rtl/ibex_ctx_register_file.sv
// Multi-context integer register file with a background clear engine that
// wipes one context word-by-word while the core keeps running.

module ibex_ctx_register_file_bank #(
    parameter int                   NumRegs     = 32,
    parameter int                   DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                we_i,
    input  logic [4:0]                          waddr_i,
    input  logic [DataWidth-1:0]                wdata_i,
    output logic [NumRegs-1:0][DataWidth-1:0]   regs_o
);

    // x0 has no storage; it is a constant tie-off.
    assign regs_o[0] = WordZeroVal;

    for (genvar r = 1; r < NumRegs; r++) begin : g_word
        logic [DataWidth-1:0] word_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_q <= WordZeroVal;
            end else if (we_i && (waddr_i == 5'(r))) begin
                word_q <= wdata_i;
            end
        end

        assign regs_o[r] = word_q;
    end

endmodule

module ibex_ctx_register_file #(
    parameter int                   NumCtx      = 2,
    parameter bit                   RV32E       = 1'b0,
    parameter int                   DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    localparam int                  CtxW        = (NumCtx > 1) ? $clog2(NumCtx) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [CtxW-1:0]      ctx_sel_i,

    input  logic [4:0]           raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [4:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,

    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 we_i,

    output logic [DataWidth-1:0] ra_o,

    input  logic                 clr_req_i,
    input  logic [CtxW-1:0]      clr_ctx_i,
    output logic                 clr_busy_o,
    output logic                 clr_done_o
);

    localparam int               NumRegs  = RV32E ? 16 : 32;
    localparam int               AW       = RV32E ? 4 : 5;
    localparam logic [5:0]       NumRegsL = 6'(NumRegs);
    localparam logic [CtxW:0]    NumCtxL  = (CtxW + 1)'(NumCtx);
    localparam logic [4:0]       LastPtr  = 5'(NumRegs - 1);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       CLEAR    = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [4:0]      ptr_q, ptr_d;
    logic [CtxW-1:0] cctx_q, cctx_d;
    logic            done_q, done_d;

    logic ctx_ok, clr_ctx_ok, core_ok, stall, eng_we;

    logic [NumCtx-1:0][NumRegs-1:0][DataWidth-1:0] bank_rd;

    assign ctx_ok     = ({1'b0, ctx_sel_i} < NumCtxL);
    assign clr_ctx_ok = ({1'b0, clr_ctx_i} < NumCtxL);
    assign core_ok    = we_i && (waddr_i != 5'd0) && ({1'b0, waddr_i} < NumRegsL) && ctx_ok;

    // A core write into the context being cleared wins the cycle; the engine
    // retries the same word next cycle, so late core writes at >= ptr still get wiped.
    assign stall  = (state_q == CLEAR) && core_ok && (ctx_sel_i == cctx_q);
    assign eng_we = (state_q == CLEAR) && !stall;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cctx_d  = cctx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i && clr_ctx_ok) begin
                    state_d = CLEAR;
                    cctx_d  = clr_ctx_i;
                    ptr_d   = 5'd1;
                end
            end
            CLEAR: begin
                if (!stall) begin
                    if (ptr_q == LastPtr) begin
                        state_d = IDLE;
                        ptr_d   = 5'd1;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 5'd1;
            cctx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cctx_q  <= cctx_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy_o = (state_q == CLEAR);
    assign clr_done_o = done_q;

    for (genvar c = 0; c < NumCtx; c++) begin : g_ctx
        logic core_hit, eng_hit;

        assign core_hit = core_ok && (ctx_sel_i == CtxW'(c));
        assign eng_hit  = eng_we && (cctx_q == CtxW'(c));

        ibex_ctx_register_file_bank #(
            .NumRegs     (NumRegs),
            .DataWidth   (DataWidth),
            .WordZeroVal (WordZeroVal)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (core_hit || eng_hit),
            .waddr_i (core_hit ? waddr_i : ptr_q),
            .wdata_i (core_hit ? wdata_i : WordZeroVal),
            .regs_o  (bank_rd[c])
        );
    end

    always_comb begin
        rdata_a_o = WordZeroVal;
        rdata_b_o = WordZeroVal;
        ra_o      = WordZeroVal;
        for (int c = 0; c < NumCtx; c++) begin
            if (ctx_sel_i == CtxW'(c)) begin
                rdata_a_o = bank_rd[c][raddr_a_i[AW-1:0]];
                rdata_b_o = bank_rd[c][raddr_b_i[AW-1:0]];
                ra_o      = bank_rd[c][1];
            end
        end
        if ({1'b0, raddr_a_i} >= NumRegsL) rdata_a_o = WordZeroVal;
        if ({1'b0, raddr_b_i} >= NumRegsL) rdata_b_o = WordZeroVal;
    end

endmodule
